// File: rtl/sub_pkg.sv
// Shared types and helpers for the chunk-serial subtractor.
// Holds the controller state encoding and the carry/borrow inversion used
// when a subtraction is carried out as an addition of the complement.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // a - b - borrow == a + ~b + ~borrow; the carry of that addition is the
    // inverse of the borrow, and the same inversion maps borrow back to carry.
    function automatic logic carry_to_borrow(input logic carry);
        return ~carry;
    endfunction

endpackage

// File: rtl/chunk_sub_cell.sv
// Combinational W-bit subtract cell: o_diff = i_a - i_b - i_bin (mod 2^W),
// o_bout set when i_a < i_b + i_bin. Built as a + ~b + ~bin so it maps onto
// a plain carry chain.
module chunk_sub_cell
    import sub_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_bin,
    output logic [W-1:0] o_diff,
    output logic         o_bout
);

    logic [W:0] w_sum;

    assign w_sum  = {1'b0, i_a} + {1'b0, ~i_b} + {{W{1'b0}}, carry_to_borrow(i_bin)};
    assign o_diff = w_sum[W-1:0];
    assign o_bout = carry_to_borrow(w_sum[W]);

endmodule

// File: rtl/chunk_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, CHUNK bits per cycle, LSB chunk
// first, with the borrow carried in a register between cycles. Valid/ready
// on both sides; one operation in flight, result held until taken.
// Optional build macro CHUNK_SERIAL_SUB_APPROX_LSB_EN: chunk 0 becomes a ^ b
// with no borrow generation (bin has no effect), latency unchanged.
module chunk_serial_subtractor
    import sub_pkg::*;
#(
    parameter int BITWIDTH = 8,
    parameter int CHUNK    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITWIDTH-1:0] a,
    input  logic [BITWIDTH-1:0] b,
    input  logic                bin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITWIDTH:0]   diff
);

    localparam int NUM_CHUNKS = BITWIDTH / CHUNK;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    generate
        if ((CHUNK < 1) || (CHUNK > BITWIDTH) || ((BITWIDTH % CHUNK) != 0)) begin : g_bad_chunk
            $error("chunk_serial_subtractor: CHUNK must divide BITWIDTH");
        end
    endgenerate

    state_t                r_state;
    state_t                w_state_next;
    logic [BITWIDTH-1:0]   r_a;
    logic [BITWIDTH-1:0]   r_b;
    logic                  r_borrow;
    logic [CNT_W-1:0]      r_cnt;
    logic [BITWIDTH:0]     r_diff;

    logic [CHUNK-1:0]      w_a_chunks [NUM_CHUNKS];
    logic [CHUNK-1:0]      w_b_chunks [NUM_CHUNKS];
    logic [CHUNK-1:0]      w_a_sel;
    logic [CHUNK-1:0]      w_b_sel;
    logic [CHUNK-1:0]      w_cell_diff;
    logic                  w_cell_bout;
    logic [CHUNK-1:0]      w_chunk_diff;
    logic                  w_chunk_bout;
    logic                  w_last;

    // Split the latched operands into chunk slices so the active one can be
    // picked by the counter.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHUNKS; gi++) begin : g_slice
            assign w_a_chunks[gi] = r_a[gi*CHUNK +: CHUNK];
            assign w_b_chunks[gi] = r_b[gi*CHUNK +: CHUNK];
        end
    endgenerate

    assign w_a_sel = w_a_chunks[r_cnt];
    assign w_b_sel = w_b_chunks[r_cnt];
    assign w_last  = (r_cnt == CNT_W'(NUM_CHUNKS - 1));

    chunk_sub_cell #(
        .W (CHUNK)
    ) u_cell (
        .i_a    (w_a_sel),
        .i_b    (w_b_sel),
        .i_bin  (r_borrow),
        .o_diff (w_cell_diff),
        .o_bout (w_cell_bout)
    );

`ifdef CHUNK_SERIAL_SUB_APPROX_LSB_EN
    // Lowest chunk is a carry-free XOR; the borrow it hands upward is zero,
    // which also makes the latched bin irrelevant.
    assign w_chunk_diff = (r_cnt == '0) ? (w_a_sel ^ w_b_sel) : w_cell_diff;
    assign w_chunk_bout = (r_cnt == '0) ? 1'b0 : w_cell_bout;
`else
    assign w_chunk_diff = w_cell_diff;
    assign w_chunk_bout = w_cell_bout;
`endif

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs; acceptance only in IDLE, result only in DONE.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Datapath: latch operands on acceptance, then fold one chunk per BUSY cycle
    // into the result; the result is left in place after the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= bin;
                        r_cnt    <= '0;
                    end
                end
                BUSY: begin
                    r_borrow <= w_chunk_bout;
                    for (int k = 0; k < NUM_CHUNKS; k++) begin
                        if (r_cnt == CNT_W'(k)) begin
                            r_diff[k*CHUNK +: CHUNK] <= w_chunk_diff;
                        end
                    end
                    if (w_last) begin
                        r_diff[BITWIDTH] <= w_chunk_bout;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign diff = r_diff;

endmodule

// File: tb/tb_chunk_serial_subtractor.sv
// Bench for chunk_serial_subtractor: one instance with CHUNK=4 and one with
// CHUNK=1 (both BITWIDTH=8), directed cases followed by random operations,
// each result compared with a plain-arithmetic reference.
module tb_chunk_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid_s  [2];
    logic       in_ready_s  [2];
    logic       out_valid_s [2];
    logic       out_ready_s [2];
    logic       bin_s       [2];
    logic [7:0] a_s         [2];
    logic [7:0] b_s         [2];
    logic [8:0] diff_s      [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    chunk_serial_subtractor #(.BITWIDTH(8), .CHUNK(4)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .a(a_s[0]), .b(b_s[0]), .bin(bin_s[0]),
        .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
        .diff(diff_s[0])
    );

    chunk_serial_subtractor #(.BITWIDTH(8), .CHUNK(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .a(a_s[1]), .b(b_s[1]), .bin(bin_s[1]),
        .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
        .diff(diff_s[1])
    );

    function automatic int chunk_of(input int sel);
        return (sel == 0) ? 4 : 1;
    endfunction

    // Reference result {borrow_out, difference} from integer arithmetic.
    function automatic logic [8:0] model(input logic [7:0] av, input logic [7:0] bv,
                                         input logic binv, input int chunk);
        int d;
`ifdef CHUNK_SERIAL_SUB_APPROX_LSB_EN
        int lo;
        int hi_a;
        int hi_b;
        lo = int'(av ^ bv) & ((1 << chunk) - 1);
        if (chunk >= 8) return {1'b0, 8'(lo)};
        hi_a = int'(av) >> chunk;
        hi_b = int'(bv) >> chunk;
        d = hi_a - hi_b;
        return {(hi_a < hi_b), 8'((d << chunk) | lo)};
`else
        d = int'(av) - int'(bv) - int'(binv);
        return {(d < 0), 8'(d)};
`endif
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction: offer, wait for the result, hold it for `hold`
    // cycles with out_ready low (offering junk on in_valid), then take it.
    task automatic run_op(input int sel, input logic [7:0] av, input logic [7:0] bv,
                          input logic binv, input int hold, input string tag);
        int lat;
        logic [8:0] exp;
        logic [8:0] held;
        exp = model(av, bv, binv, chunk_of(sel));
        @(negedge clk);
        chk({tag, "_ready_idle"}, 16'(in_ready_s[sel]), 16'd1);
        in_valid_s[sel] = 1'b1;
        a_s[sel] = av;
        b_s[sel] = bv;
        bin_s[sel] = binv;
        @(posedge clk);
        @(negedge clk);
        in_valid_s[sel] = 1'b0;
        a_s[sel] = 8'($urandom);
        b_s[sel] = 8'($urandom);
        lat = 0;
        while (out_valid_s[sel] !== 1'b1 && lat < 40) begin
            chk({tag, "_ready_busy"}, 16'(in_ready_s[sel]), 16'd0);
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 16'(lat), 16'(8 / chunk_of(sel)));
        chk({tag, "_diff"}, 16'(diff_s[sel]), 16'(exp));
        held = exp;
        for (int h = 0; h < hold; h++) begin
            in_valid_s[sel] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_hold_valid"}, 16'(out_valid_s[sel]), 16'd1);
            chk({tag, "_hold_diff"}, 16'(diff_s[sel]), 16'(held));
            chk({tag, "_hold_ready"}, 16'(in_ready_s[sel]), 16'd0);
        end
        in_valid_s[sel] = 1'b0;
        out_ready_s[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_s[sel] = 1'b0;
        chk({tag, "_valid_drop"}, 16'(out_valid_s[sel]), 16'd0);
        chk({tag, "_ready_back"}, 16'(in_ready_s[sel]), 16'd1);
        chk({tag, "_diff_kept"}, 16'(diff_s[sel]), 16'(held));
        $display("OP %s dut%0d a=%02h b=%02h bin=%0d diff=%03h exp=%03h lat=%0d hold=%0d",
                 tag, sel, av, bv, binv, diff_s[sel], exp, lat, hold);
    endtask

    initial begin
        int first;
        int second;
        int wait_cnt;
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            in_valid_s[s] = 1'b0;
            out_ready_s[s] = 1'b0;
            a_s[s] = 8'h00;
            b_s[s] = 8'h00;
            bin_s[s] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("reset_in_ready", 16'(in_ready_s[s]), 16'd1);
            chk("reset_out_valid", 16'(out_valid_s[s]), 16'd0);
            chk("reset_diff", 16'(diff_s[s]), 16'd0);
        end
        rst = 1'b0;

        // Directed arithmetic cases.
        run_op(0, 8'h35, 8'h12, 1'b0, 0, "d_35_12");
        run_op(0, 8'h00, 8'h01, 1'b0, 0, "d_00_01");
        run_op(0, 8'hFF, 8'hFF, 1'b1, 0, "d_FF_FF_b1");
        run_op(0, 8'h30, 8'h01, 1'b1, 0, "d_30_01_b1");
        run_op(0, 8'hA7, 8'h00, 1'b0, 0, "d_b_zero");

        // Backpressure: result held 10 cycles while junk is offered.
        run_op(0, 8'h5A, 8'h3C, 1'b1, 10, "bp_hold10");

        // Reset during the second BUSY cycle.
        @(negedge clk);
        in_valid_s[0] = 1'b1;
        a_s[0] = 8'hAB;
        b_s[0] = 8'h12;
        bin_s[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid_s[0] = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 16'(out_valid_s[0]), 16'd0);
        chk("midrst_in_ready", 16'(in_ready_s[0]), 16'd1);
        chk("midrst_diff", 16'(diff_s[0]), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("midrst_no_valid", 16'(out_valid_s[0]), 16'd0);
        end
        run_op(0, 8'h10, 8'h01, 1'b0, 0, "post_rst_10_01");

        // CHUNK=1 instance: 8-cycle latency.
        run_op(1, 8'h80, 8'h7F, 1'b0, 0, "c1_80_7F");

        // CHUNK=1 back-to-back: in_valid held high, acceptances NUM_CHUNKS+2 apart.
        @(negedge clk);
        a_s[1] = 8'h80;
        b_s[1] = 8'h7F;
        bin_s[1] = 1'b0;
        in_valid_s[1] = 1'b1;
        out_ready_s[1] = 1'b1;
        first = -1;
        second = -1;
        for (int c = 0; c < 30; c++) begin
            if (in_ready_s[1] === 1'b1) begin
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid_s[1] = 1'b0;
        chk("b2b_interval", 16'(second - first), 16'd10);
        wait_cnt = 0;
        while (in_ready_s[1] !== 1'b1 && wait_cnt < 20) begin
            @(posedge clk);
            @(negedge clk);
            wait_cnt++;
        end
        out_ready_s[1] = 1'b0;
        chk("b2b_drain_ready", 16'(in_ready_s[1]), 16'd1);
        chk("b2b_diff", 16'(diff_s[1]), 16'(model(8'h80, 8'h7F, 1'b0, 1)));
        $display("OP b2b dut1 first=%0d second=%0d interval=%0d", first, second, second - first);

        // Random operations on both instances.
        for (int i = 0; i < 24; i++) begin
            run_op((i % 4 == 3) ? 1 : 0, 8'($urandom), 8'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/chunk_serial_subtractor.md
Name: chunk_serial_subtractor

Overview:
- Multi-cycle subtractor: computes diff = a - b - bin over BITWIDTH-bit unsigned operands.
- Processes CHUNK bits per cycle, LSB chunk first, and carries the borrow in a register between cycles.
- Sits next to the CLA adder in the DNN datapath as its area-lean inverse, for accumulator decrement and residual computation.
- Uses a valid/ready handshake on both input and output.

Parameters:
- BITWIDTH, 8, operand width. BITWIDTH % CHUNK == 0 is mandatory; violating it is an elaboration error.
- CHUNK, 4, bits processed per cycle, 1..BITWIDTH.
- NUM_CHUNKS is derived: BITWIDTH/CHUNK. It is a localparam, not overridable.

Ports:
- clk  in  1  sole clock; all state is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  BITWIDTH  minuend.
- b  in  BITWIDTH  subtrahend.
- bin  in  1  borrow-in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- diff  out  BITWIDTH+1  diff[BITWIDTH-1:0] is the difference mod 2^BITWIDTH; diff[BITWIDTH] is borrow-out (1 when a < b + bin).

Behaviour:
- Reset (async assert, sync release): state=IDLE, chunk counter=0, borrow reg=0, operand regs=0, diff=0, in_ready=1, out_valid=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch a, b, bin into the borrow reg; set counter=0; go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle, chunk k=counter computes a[k] + ~b[k] + ~borrow as a CHUNK-bit add.
  - Result bits are written into diff[k*CHUNK +: CHUNK]. The borrow reg takes the inverted chunk carry-out.
  - When counter==NUM_CHUNKS-1: write diff[BITWIDTH] = final borrow and go to DONE. Otherwise counter+1.
- DONE:
  - out_valid=1; diff is held stable.
  - On out_ready: out_valid drops next cycle and the FSM returns to IDLE.
  - in_ready stays 0 in DONE; there is no overlap of new acceptance with result hold.
- Latency: acceptance edge to out_valid high is NUM_CHUNKS cycles. Minimum issue interval is NUM_CHUNKS+2 cycles.
- Backpressure: out_ready low holds DONE indefinitely, with diff and out_valid unchanged.
- in_valid while BUSY/DONE is ignored and is not queued. The source must keep it asserted until in_ready.
- Arithmetic:
  - All unsigned; wrap-around mod 2^BITWIDTH.
  - CHUNK==BITWIDTH degenerates to a single BUSY cycle.
  - b=0, bin=0 gives diff={1'b0,a}.
- Mid-operation reset: all state returns to reset values immediately. The partial result is discarded and out_valid is never asserted for it.
- diff is not cleared on return to IDLE. It holds the last result until the next BUSY overwrites it chunk by chunk. Consumers use it only under out_valid.

Optional Feature:
- Macro: CHUNK_SERIAL_SUB_APPROX_LSB_EN.
- Defined (approximate mode):
  - Chunk 0 is computed as a[CHUNK-1:0] ^ b[CHUNK-1:0] with no borrow generation.
  - bin is ignored, and the borrow into chunk 1 is forced to 0.
  - Latency is unchanged.
- Undefined: exact subtraction as above.
- In both modes, diff[BITWIDTH] reflects the borrow chain as actually computed.

Decomposition:
- Package sub_pkg: state enum (IDLE, BUSY, DONE) and the borrow/carry inversion helper function.
- One sub-module, chunk_sub_cell: a combinational CHUNK-bit a - b - bin.
  - Outputs: CHUNK-bit difference and borrow-out.
  - Instantiated once; the FSM muxes operand chunk k into it.

Test Plan:
- Defaults, exact mode. a=0x35, b=0x12, bin=0 -> after 2 BUSY cycles, out_valid=1 with diff=0x023.
- a=0x00, b=0x01, bin=0 -> diff=0x1FF (borrow-out 1). a=0xFF, b=0xFF, bin=1 -> diff=0x1FF.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after DONE -> diff and out_valid remain stable and in_ready stays 0.
  - Then raise out_ready -> IDLE next cycle and in_ready=1.
- Reset mid-operation: assert rst during the second BUSY cycle -> out_valid=0, in_ready=1, and diff=0 immediately. The next operation a=0x10, b=0x01 -> diff=0x00F.
- CHUNK_SERIAL_SUB_APPROX_LSB_EN defined: a=0x30, b=0x01, bin=1 -> diff=0x031 (exact result would be 0x02E).
- CHUNK=1, BITWIDTH=8: a=0x80, b=0x7F -> out_valid exactly 8 cycles after acceptance, diff=0x001. Back-to-back in_valid is accepted only after the DONE handshake.
